// File: rtl/pxs_color_bars_checker.sv
// Colour-bar stream checker: recomputes the bar colour per pixel, counts mismatches per frame, publishes a verdict on each VS entry.
// Latency: boundary sampled at edge k -> frame_done in cycle k+2. No backpressure (pure sink).
module pxs_color_bars_checker #(
  parameter int unsigned BAR_LSB = 3,
  parameter int unsigned ERR_W   = 16,
  parameter bit          VS_POL  = 1'b0
) (
  input  logic             px_clk,
  input  logic             rst,
  input  logic [25:0]      RGBStr_i,
  output logic             frame_done,
  output logic             frame_ok,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       first_err_x,
  output logic [9:0]       first_err_y,
  output logic [15:0]      frame_cnt,
  output logic             locked
);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       active;
    logic [2:0] rgb;
  } px_t;

  typedef struct packed {
    logic [ERR_W-1:0] err;
    logic [19:0]      px;
    logic             seen;
    logic [9:0]       x;
    logic [9:0]       y;
  } acc_t;

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

  state_t           state_q, state_d;
  px_t              s1_q;
  logic             vs_prev_q;
  acc_t             acc_q, acc_d, pend_q, pend_d;
  logic             locked_q, locked_d, done_q, done_d, ok_q, ok_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [9:0]       fx_q, fx_d, fy_q, fy_d;
  logic [15:0]      fcnt_q, fcnt_d;

  logic [2:0] exp_rgb;
  logic       mism, boundary, unused_hs;
  acc_t       step_cur, step_fresh, step_pend;

  function automatic acc_t step(input acc_t a, input logic m, input logic act,
                                input logic [9:0] x, input logic [9:0] y);
    acc_t r;
    r = a;
    if (m && (a.err != '1)) r.err = a.err + ERR_W'(1);
    if (act && (a.px != '1)) r.px = a.px + 20'd1;
    if (m && !a.seen) begin
      r.seen = 1'b1;
      r.x    = x;
      r.y    = y;
    end
    return r;
  endfunction

  assign unused_hs  = &{1'b0, s1_q.hs};
  assign exp_rgb    = s1_q.active ? s1_q.xc[BAR_LSB+2:BAR_LSB] : 3'b000;
  assign mism       = (s1_q.rgb != exp_rgb);
  assign boundary   = (s1_q.vs == VS_POL) && (vs_prev_q != VS_POL);
  assign step_cur   = step(acc_q, mism, s1_q.active, s1_q.xc, s1_q.yc);
  assign step_fresh = step('0, mism, s1_q.active, s1_q.xc, s1_q.yc);
  assign step_pend  = step(pend_q, mism, s1_q.active, s1_q.xc, s1_q.yc);

  // The boundary pixel opens the new frame; it is parked in pend_q while acc_q still holds the old totals.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pend_d   = pend_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    ok_d     = ok_q;
    err_d    = err_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    fcnt_d   = fcnt_q;
    case (state_q)
      IDLE: begin
        if (boundary) begin
          state_d  = CHECK;
          acc_d    = step_fresh;
          locked_d = 1'b1;
        end
      end
      CHECK: begin
        if (boundary) begin
          state_d = REPORT;
          pend_d  = step_fresh;
        end else begin
          acc_d = step_cur;
        end
      end
      REPORT: begin
        state_d = CHECK;
        acc_d   = step_pend;
        done_d  = 1'b1;
        err_d   = acc_q.err;
        fx_d    = acc_q.seen ? acc_q.x : 10'd0;
        fy_d    = acc_q.seen ? acc_q.y : 10'd0;
        ok_d    = (acc_q.err == '0) && (acc_q.px != '0);
        fcnt_d  = fcnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage-1 VS resets inactive so the idle stream cannot look like a sync entry.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= '0;
      s1_q.vs   <= ~VS_POL;
      vs_prev_q <= ~VS_POL;
      acc_q     <= '0;
      pend_q    <= '0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= '0;
      fx_q      <= '0;
      fy_q      <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= px_t'(RGBStr_i);
      vs_prev_q <= s1_q.vs;
      acc_q     <= acc_d;
      pend_q    <= pend_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign frame_done  = done_q;
  assign frame_ok    = ok_q;
  assign err_cnt     = err_q;
  assign first_err_x = fx_q;
  assign first_err_y = fy_q;
  assign frame_cnt   = fcnt_q;
  assign locked      = locked_q;

endmodule
